// File: rtl/morse_bit_sequencer.sv
// morse_bit_sequencer: walks the Morse pattern bit index, holding each index for one time unit, then inserts an inter-character gap and pulses done.
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  transmission request, sampled only while idle
//   length  in   5  number of pattern bits to emit (1..MAX_LEN)
//   sel     out  5  bit index to the pattern mux, PARK_SEL when silent
//   tx_en   out  1  high while sel points at a valid pattern bit
//   busy    out  1  high from accept through the end of the gap
//   done    out  1  one-cycle completion pulse
module morse_bit_sequencer #(
    parameter int          UNIT_CYCLES = 12_500_000,
    parameter int          GAP_UNITS   = 3,
    parameter int          MAX_LEN     = 22,
    parameter logic [4:0]  PARK_SEL    = 5'd22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] length,
    output logic [4:0] sel,
    output logic       tx_en,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(UNIT_CYCLES + 1);
    localparam int GW = $clog2(GAP_UNITS + 1);
    localparam logic [CW-1:0] UNIT_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_UNITS - 1);
    localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gcnt;
    logic [4:0]    r_len;
    logic [4:0]    r_sel;
    logic          r_tx_en;
    logic          r_busy;
    logic          r_done;
    logic          w_unit_end;
    logic          w_accept;

    assign w_unit_end = r_cnt == UNIT_LAST;
    assign w_accept   = start && length != 5'd0 && length <= LEN_MAX;
    assign sel   = r_sel;
    assign tx_en = r_tx_en;
    assign busy  = r_busy;
    assign done  = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_len   <= '0;
            r_sel   <= PARK_SEL;
            r_tx_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    r_cnt <= w_unit_end ? '0 : r_cnt + 1'b1;
                    if (w_unit_end && r_sel == r_len - 5'd1) begin
                        r_state <= GAP;
                        r_sel   <= PARK_SEL;
                        r_tx_en <= 1'b0;
                        r_gcnt  <= '0;
                    end else if (w_unit_end) begin
                        r_sel <= r_sel + 5'd1;
                    end
                end
                GAP: begin
                    r_cnt <= w_unit_end ? '0 : r_cnt + 1'b1;
                    if (w_unit_end && r_gcnt == GAP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_unit_end) begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_len   <= length;
                        r_sel   <= 5'd0;
                        r_tx_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_morse_bit_sequencer.sv
// tb_morse_bit_sequencer: directed checks of the bit sequencer with unit lengths of 4 and 1 clocks.
module tb_morse_bit_sequencer;
    typedef struct {
        logic       start;
        logic [4:0] len;
        logic [4:0] sel;
        logic       tx_en;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_start = 1'b0, b_start = 1'b0;
    logic [4:0] a_len = 5'd0, b_len = 5'd0;
    logic [4:0] a_sel, b_sel;
    logic       a_tx, a_busy, a_done, b_tx, b_busy, b_done;
    int         n_pass = 0;
    int         n_tot = 0;
    vec_t       vec[26];

    always #5 clk = ~clk;

    morse_bit_sequencer #(.UNIT_CYCLES(4), .GAP_UNITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .length(a_len),
        .sel(a_sel), .tx_en(a_tx), .busy(a_busy), .done(a_done)
    );

    morse_bit_sequencer #(.UNIT_CYCLES(1), .GAP_UNITS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .length(b_len),
        .sel(b_sel), .tx_en(b_tx), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input int s, input int t, input int b, input int d);
        chk({name, "_sel"}, int'(a_sel), s);
        chk({name, "_tx"}, int'(a_tx), t);
        chk({name, "_busy"}, int'(a_busy), b);
        chk({name, "_done"}, int'(a_done), d);
    endtask

    initial begin
        // cycle k after the accepting edge: sel=(k-1)/4 for k<=12, park after
        for (int i = 0; i < 26; i++) begin
            vec[i].start = (i == 0) || (i == 6);
            vec[i].len   = (i == 0) ? 5'd3 : 5'd7;
            vec[i].sel   = (i + 1 <= 12) ? 5'(i / 4) : 5'd22;
            vec[i].tx_en = (i + 1 <= 12);
            vec[i].busy  = (i + 1 <= 24);
            vec[i].done  = (i + 1 == 25);
        end

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_a("rst_async", 22, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("rst_hold", 22, 0, 0, 0);
        end
        rst_n = 1'b1;
        step();
        chk_a("rst_rel", 22, 0, 0, 0);
        chk("rst_b_sel", int'(b_sel), 22);

        for (int i = 0; i < 26; i++) begin
            a_start = vec[i].start;
            a_len   = vec[i].len;
            step();
            chk_a($sformatf("len3_c%0d", i + 1), int'(vec[i].sel), int'(vec[i].tx_en),
                  int'(vec[i].busy), int'(vec[i].done));
        end
        a_start = 1'b0;

        a_start = 1'b1;
        a_len   = 5'd22;
        step();
        a_start = 1'b0;
        for (int k = 1; k <= 102; k++) begin
            chk("len22_sel", int'(a_sel), k <= 88 ? (k - 1) / 4 : 22);
            chk("len22_tx", int'(a_tx), int'(k <= 88));
            chk("len22_done", int'(a_done), int'(k == 101));
            if (a_tx) chk("len22_nopark", int'(a_sel != 5'd22), 1);
            if (k < 102) step();
        end

        a_start = 1'b1;
        a_len   = 5'd0;
        step();
        chk_a("len0", 22, 0, 0, 0);
        a_len = 5'd23;
        step();
        chk_a("len23", 22, 0, 0, 0);
        a_len = 5'd2;
        step();
        a_start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            chk_a($sformatf("len2_c%0d", k), k <= 8 ? (k - 1) / 4 : 22, int'(k <= 8),
                  int'(k <= 20), int'(k == 21));
            if (k == 3) begin
                a_start = 1'b1;
                a_len   = 5'd5;
            end
            step();
            a_start = 1'b0;
        end

        a_start = 1'b1;
        a_len   = 5'd22;
        step();
        a_start = 1'b0;
        for (int k = 1; k < 22; k++) step();
        chk("abort_pre_sel", int'(a_sel), 5);
        rst_n = 1'b0;
        #1 chk_a("abort_async", 22, 0, 0, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 120; k++) begin
            step();
            if (a_done || a_busy || a_tx) chk("abort_quiet", int'({a_done, a_busy, a_tx}), 0);
        end
        chk_a("abort_end", 22, 0, 0, 0);

        b_start = 1'b1;
        b_len   = 5'd1;
        step();
        b_start = 1'b0;
        chk("u1_c1_sel", int'(b_sel), 0);
        chk("u1_c1_tx", int'(b_tx), 1);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("u1_c%0d_sel", k), int'(b_sel), 22);
            chk($sformatf("u1_c%0d_busy", k), int'(b_busy), 1);
            chk($sformatf("u1_c%0d_done", k), int'(b_done), 0);
        end
        step();
        chk("u1_c5_done", int'(b_done), 1);
        chk("u1_c5_busy", int'(b_busy), 0);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("u1_c6_sel", int'(b_sel), 0);
        chk("u1_c6_busy", int'(b_busy), 1);
        chk("u1_c6_done", int'(b_done), 0);
        for (int k = 7; k <= 10; k++) step();
        chk("u1_c10_done", int'(b_done), 1);
        step();
        chk("u1_c11_done", int'(b_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
